// File: rtl/mul_arb_pkg.sv
// Shared types for the two-requester multiplier arbiter: operand/product widths
// and the tag that follows each product through the multiplier latency.
package mul_arb_pkg;

    typedef logic [31:0] operand_t;
    typedef logic [63:0] product_t;

    typedef struct packed {
        logic valid;
        logic id;
    } mul_tag_t;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/mul_resp_fifo.sv
// Per-requester response FIFO: circular buffer with an occupancy count that the
// arbiter reads back as part of its credit check.
module mul_resp_fifo
    import mul_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  product_t      push_data,
    input  logic          pop,
    output logic          valid,
    output product_t      head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    product_t      mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid  = (count != '0);
    assign head   = valid ? mem[rd_ptr] : '0;
    assign do_pop = pop && valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Push and pop in the same cycle leave the count untouched, even when full:
    // the head is read combinationally before the slot is rewritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/multiplier_arbiter.sv
// Round-robin sharing of one 32x32->64 unsigned multiplier between two requesters,
// with credit-limited issue, a tag pipeline matching the multiplier latency, and per-requester response FIFOs.
module multiplier_arbiter
    import mul_arb_pkg::*;
#(
    parameter int MUL_LATENCY = 0,
    parameter int RESP_DEPTH  = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     req0_valid,
    output logic     req0_ready,
    input  operand_t req0_a,
    input  operand_t req0_b,
    input  logic     req1_valid,
    output logic     req1_ready,
    input  operand_t req1_a,
    input  operand_t req1_b,
    output logic     resp0_valid,
    input  logic     resp0_ready,
    output product_t resp0_r,
    output logic     resp1_valid,
    input  logic     resp1_ready,
    output product_t resp1_r,
    output operand_t mul_a,
    output operand_t mul_b,
    input  product_t mul_r
);

    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int OW = 5;

    // Handshake: a transfer happens on any cycle where valid && ready are both high;
    // the source holds its payload stable while valid && !ready, and ready never waits on a later cycle.
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] resp_ready;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] fifo_valid;
    logic [NUM_REQ-1:0] fifo_push;
    product_t           fifo_head  [NUM_REQ];
    logic [CW-1:0]      fifo_count [NUM_REQ];
    logic [2:0]         inflight   [NUM_REQ];
    logic               last_grant;
    mul_tag_t           issue_tag;
    mul_tag_t           cap_tag;

    assign req_valid  = {req1_valid, req0_valid};
    assign resp_ready = {resp1_ready, resp0_ready};

    always_comb begin
        eligible = '0;
        grant    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i]
                && ((OW'(inflight[i]) + OW'(fifo_count[i])) < OW'(RESP_DEPTH));
        end
        if (!reset) begin
            if (&eligible) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = eligible;
            end
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (grant[0]) begin
            mul_a = req0_a;
            mul_b = req0_b;
        end else if (grant[1]) begin
            mul_a = req1_a;
            mul_b = req1_b;
        end
    end

    assign issue_tag.valid = |grant;
    assign issue_tag.id    = grant[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

    generate
        if (MUL_LATENCY == 0) begin : g_comb
            assign cap_tag     = issue_tag;
            assign inflight[0] = '0;
            assign inflight[1] = '0;
        end else begin : g_pipe
            mul_tag_t pipe [MUL_LATENCY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < MUL_LATENCY; i++) begin
                        pipe[i] <= '0;
                    end
                end else begin
                    pipe[0] <= issue_tag;
                    for (int i = 1; i < MUL_LATENCY; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign cap_tag = pipe[MUL_LATENCY-1];

            // A tag still counts as in flight on the cycle it emerges; it moves
            // into the FIFO count at the same edge, so credit never double-counts.
            always_comb begin
                inflight[0] = '0;
                inflight[1] = '0;
                for (int i = 0; i < MUL_LATENCY; i++) begin
                    if (pipe[i].valid) begin
                        inflight[pipe[i].id] = inflight[pipe[i].id] + 3'd1;
                    end
                end
            end
        end
    endgenerate

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        assign fifo_push[g] = cap_tag.valid && (cap_tag.id == 1'(g));

        mul_resp_fifo #(
            .DEPTH (RESP_DEPTH),
            .CW    (CW)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (fifo_push[g]),
            .push_data (mul_r),
            .pop       (resp_ready[g] && !reset),
            .valid     (fifo_valid[g]),
            .head      (fifo_head[g]),
            .count     (fifo_count[g])
        );
    end

    assign resp0_valid = fifo_valid[0] && !reset;
    assign resp1_valid = fifo_valid[1] && !reset;
    assign resp0_r     = reset ? '0 : fifo_head[0];
    assign resp1_r     = reset ? '0 : fifo_head[1];

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed and random bench for multiplier_arbiter: a combinational-multiplier instance (c_*)
// and a three-stage-multiplier instance (p_*), each checked against a product scoreboard.
module tb_multiplier_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        c_req0_valid, c_req0_ready, c_req1_valid, c_req1_ready;
    logic [31:0] c_req0_a, c_req0_b, c_req1_a, c_req1_b, c_mul_a, c_mul_b;
    logic        c_resp0_valid, c_resp0_ready, c_resp1_valid, c_resp1_ready;
    logic [63:0] c_resp0_r, c_resp1_r, c_mul_r;

    logic        p_req0_valid, p_req0_ready, p_req1_valid, p_req1_ready;
    logic [31:0] p_req0_a, p_req0_b, p_req1_a, p_req1_b, p_mul_a, p_mul_b;
    logic        p_resp0_valid, p_resp0_ready, p_resp1_valid, p_resp1_ready;
    logic [63:0] p_resp0_r, p_resp1_r, p_mul_r;
    logic [63:0] p_pipe [3];

    // Scoreboard slots: 0/1 = c requester 0/1, 2/3 = p requester 0/1
    logic [63:0] exp_q [4][$];
    int          recv [4];
    int          checks = 0;
    int          errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- multiplier models ----------------
    assign c_mul_r = {32'd0, c_mul_a} * {32'd0, c_mul_b};

    always @(posedge clk) begin
        p_pipe[0] <= {32'd0, p_mul_a} * {32'd0, p_mul_b};
        p_pipe[1] <= p_pipe[0];
        p_pipe[2] <= p_pipe[1];
    end
    assign p_mul_r = p_pipe[2];

    multiplier_arbiter #(.MUL_LATENCY(0), .RESP_DEPTH(2)) dut_c (
        .clk (clk), .reset (reset),
        .req0_valid (c_req0_valid), .req0_ready (c_req0_ready), .req0_a (c_req0_a), .req0_b (c_req0_b),
        .req1_valid (c_req1_valid), .req1_ready (c_req1_ready), .req1_a (c_req1_a), .req1_b (c_req1_b),
        .resp0_valid (c_resp0_valid), .resp0_ready (c_resp0_ready), .resp0_r (c_resp0_r),
        .resp1_valid (c_resp1_valid), .resp1_ready (c_resp1_ready), .resp1_r (c_resp1_r),
        .mul_a (c_mul_a), .mul_b (c_mul_b), .mul_r (c_mul_r)
    );

    multiplier_arbiter #(.MUL_LATENCY(3), .RESP_DEPTH(2)) dut_p (
        .clk (clk), .reset (reset),
        .req0_valid (p_req0_valid), .req0_ready (p_req0_ready), .req0_a (p_req0_a), .req0_b (p_req0_b),
        .req1_valid (p_req1_valid), .req1_ready (p_req1_ready), .req1_a (p_req1_a), .req1_b (p_req1_b),
        .resp0_valid (p_resp0_valid), .resp0_ready (p_resp0_ready), .resp0_r (p_resp0_r),
        .resp1_valid (p_resp1_valid), .resp1_ready (p_resp1_ready), .resp1_r (p_resp1_r),
        .mul_a (p_mul_a), .mul_b (p_mul_b), .mul_r (p_mul_r)
    );

    // ---------------- check / scoreboard ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb(input int k, input logic acc, input logic [31:0] a, input logic [31:0] b,
                      input logic pop, input logic [63:0] r);
        logic [63:0] e;
        if (pop) begin
            chk($sformatf("sb%0d_nonempty", k), 64'(exp_q[k].size() != 0), 64'd1);
            if (exp_q[k].size() != 0) begin
                e = exp_q[k].pop_front();
                chk($sformatf("sb%0d_product", k), r, e);
                recv[k]++;
            end
        end
        if (acc) begin
            exp_q[k].push_back({32'd0, a} * {32'd0, b});
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            sb(0, c_req0_valid && c_req0_ready, c_req0_a, c_req0_b, c_resp0_valid && c_resp0_ready, c_resp0_r);
            sb(1, c_req1_valid && c_req1_ready, c_req1_a, c_req1_b, c_resp1_valid && c_resp1_ready, c_resp1_r);
            sb(2, p_req0_valid && p_req0_ready, p_req0_a, p_req0_b, p_resp0_valid && p_resp0_ready, p_resp0_r);
            sb(3, p_req1_valid && p_req1_ready, p_req1_a, p_req1_b, p_resp1_valid && p_resp1_ready, p_resp1_r);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_op();
        return ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic acc0, acc1, pend0, pend1;
        int   n0, sent0, sent1, cyc;

        reset = 1'b1;
        {c_req0_valid, c_req1_valid, c_resp0_ready, c_resp1_ready} = '0;
        {p_req0_valid, p_req1_valid, p_resp0_ready, p_resp1_ready} = '0;
        {c_req0_a, c_req0_b, c_req1_a, c_req1_b} = '0;
        {p_req0_a, p_req0_b, p_req1_a, p_req1_b} = '0;

        // Reset state: valid requests are ignored and every output is zero
        c_req0_valid = 1'b1; c_req0_a = 32'd3; c_req0_b = 32'd5;
        p_req1_valid = 1'b1; p_req1_a = 32'd9; p_req1_b = 32'd4;
        tick(); mid();
        chk("rst_c_req0_ready", 64'(c_req0_ready), 64'd0);
        chk("rst_c_mul_a", 64'(c_mul_a), 64'd0);
        chk("rst_c_resp0_valid", 64'(c_resp0_valid), 64'd0);
        chk("rst_c_resp0_r", c_resp0_r, 64'd0);
        chk("rst_p_req1_ready", 64'(p_req1_ready), 64'd0);
        chk("rst_p_mul_b", 64'(p_mul_b), 64'd0);

        // Test 1: single 3*5 on the combinational instance
        tick();
        reset = 1'b0; p_req1_valid = 1'b0;
        mid();
        chk("t1_req0_ready", 64'(c_req0_ready), 64'd1);
        chk("t1_mul_a", 64'(c_mul_a), 64'd3);
        chk("t1_mul_b", 64'(c_mul_b), 64'd5);
        chk("t1_resp_valid_T", 64'(c_resp0_valid), 64'd0);
        tick();
        c_req0_valid = 1'b0;
        mid();
        chk("t1_resp_valid_T1", 64'(c_resp0_valid), 64'd1);
        chk("t1_resp_r", c_resp0_r, 64'd15);
        chk("t1_mul_a_idle", 64'(c_mul_a), 64'd0);
        tick();
        c_resp0_ready = 1'b1;
        tick(); mid();
        chk("t1_drained", 64'(c_resp0_valid), 64'd0);

        // Test 2: both requesters valid after reset alternate, requester 0 first
        tick(); reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        c_req0_valid = 1'b1; c_req0_a = rand_op(); c_req0_b = rand_op();
        c_req1_valid = 1'b1; c_req1_a = rand_op(); c_req1_b = rand_op();
        c_resp0_ready = 1'b1; c_resp1_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mid();
            chk($sformatf("t2_grant0_k%0d", k), 64'(c_req0_ready), 64'(k % 2 == 0));
            chk($sformatf("t2_grant1_k%0d", k), 64'(c_req1_ready), 64'(k % 2 == 1));
            acc0 = c_req0_ready; acc1 = c_req1_ready;
            tick();
            if (acc0) begin c_req0_a = rand_op(); c_req0_b = rand_op(); end
            if (acc1) begin c_req1_a = rand_op(); c_req1_b = rand_op(); end
        end
        c_req0_valid = 1'b0; c_req1_valid = 1'b0;
        repeat (3) tick();

        // Test 3: requester 0 backpressured -> two credits, requester 1 keeps flowing
        c_resp0_ready = 1'b0; c_resp1_ready = 1'b1;
        c_req0_valid = 1'b1; c_req1_valid = 1'b1;
        n0 = 0;
        for (int k = 0; k < 10; k++) begin
            mid();
            if (k >= 5) begin
                chk($sformatf("t3_req0_stalled_k%0d", k), 64'(c_req0_ready), 64'd0);
                chk($sformatf("t3_req1_served_k%0d", k), 64'(c_req1_ready), 64'd1);
            end
            acc0 = c_req0_ready; acc1 = c_req1_ready;
            if (acc0) n0++;
            tick();
            if (acc0) begin c_req0_a = rand_op(); c_req0_b = rand_op(); end
            if (acc1) begin c_req1_a = rand_op(); c_req1_b = rand_op(); end
        end
        chk("t3_accepted0", 64'(n0), 64'd2);
        c_req0_valid = 1'b0; c_req1_valid = 1'b0; c_resp0_ready = 1'b1;
        repeat (4) tick();
        mid();
        chk("t3_drained", 64'(c_resp0_valid), 64'd0);

        // Test 4: operand extremes
        tick();
        c_resp0_ready = 1'b0; c_resp1_ready = 1'b0;
        c_req1_valid = 1'b1; c_req1_a = 32'hFFFF_FFFF; c_req1_b = 32'hFFFF_FFFF;
        mid();
        chk("t4_max_ready", 64'(c_req1_ready), 64'd1);
        chk("t4_max_mul_a", 64'(c_mul_a), 64'h0000_0000_FFFF_FFFF);
        tick();
        c_req1_valid = 1'b0;
        c_req0_valid = 1'b1; c_req0_a = 32'd0; c_req0_b = $urandom | 32'd1;
        mid();
        chk("t4_max_r", c_resp1_r, 64'hFFFF_FFFE_0000_0001);
        chk("t4_zero_ready", 64'(c_req0_ready), 64'd1);
        tick();
        c_req0_valid = 1'b0;
        mid();
        chk("t4_zero_valid", 64'(c_resp0_valid), 64'd1);
        chk("t4_zero_r", c_resp0_r, 64'd0);
        tick();
        c_resp0_ready = 1'b1; c_resp1_ready = 1'b1;
        repeat (3) tick();

        // Test 5: reset with two products in flight on the 3-cycle instance
        p_resp0_ready = 1'b1; p_resp1_ready = 1'b1;
        p_req0_valid = 1'b1; p_req0_a = 32'd7;  p_req0_b = 32'd9;
        p_req1_valid = 1'b1; p_req1_a = 32'd11; p_req1_b = 32'd13;
        mid();
        chk("t5_first_grant0", 64'(p_req0_ready), 64'd1);
        tick();
        p_req0_valid = 1'b0;
        mid();
        chk("t5_second_grant1", 64'(p_req1_ready), 64'd1);
        tick();
        p_req1_valid = 1'b0; p_req0_valid = 1'b1; reset = 1'b1;
        mid();
        chk("t5_rst_req0_ready", 64'(p_req0_ready), 64'd0);
        chk("t5_rst_mul_a", 64'(p_mul_a), 64'd0);
        exp_q[2].delete(); exp_q[3].delete();
        tick(); mid();
        chk("t5_rst_resp0_valid", 64'(p_resp0_valid), 64'd0);
        chk("t5_rst_resp1_valid", 64'(p_resp1_valid), 64'd0);
        tick();
        reset = 1'b0; p_req0_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mid();
            chk($sformatf("t5_no_resp0_k%0d", k), 64'(p_resp0_valid), 64'd0);
            chk($sformatf("t5_no_resp1_k%0d", k), 64'(p_resp1_valid), 64'd0);
            tick();
        end

        // Test 6: 100 random ops per requester with random response backpressure
        recv[2] = 0; recv[3] = 0;
        sent0 = 0; sent1 = 0; cyc = 0; acc0 = 1'b0; acc1 = 1'b0;
        while ((sent0 < 100 || sent1 < 100) && cyc < 6000) begin
            pend0 = p_req0_valid && !acc0;
            pend1 = p_req1_valid && !acc1;
            if (!pend0) begin
                p_req0_valid = (sent0 < 100) && ($urandom_range(0, 3) != 0);
                p_req0_a = rand_op(); p_req0_b = rand_op();
            end
            if (!pend1) begin
                p_req1_valid = (sent1 < 100) && ($urandom_range(0, 3) != 0);
                p_req1_a = rand_op(); p_req1_b = rand_op();
            end
            p_resp0_ready = ($urandom_range(0, 2) != 0);
            p_resp1_ready = ($urandom_range(0, 2) != 0);
            mid();
            acc0 = p_req0_valid && p_req0_ready;
            acc1 = p_req1_valid && p_req1_ready;
            if (acc0) sent0++;
            if (acc1) sent1++;
            cyc++;
            tick();
        end
        chk("t6_sent0", 64'(sent0), 64'd100);
        chk("t6_sent1", 64'(sent1), 64'd100);
        p_req0_valid = 1'b0; p_req1_valid = 1'b0;
        p_resp0_ready = 1'b1; p_resp1_ready = 1'b1;
        cyc = 0;
        while ((exp_q[2].size() != 0 || exp_q[3].size() != 0) && cyc < 50) begin
            tick();
            cyc++;
        end
        tick(); mid();
        chk("t6_q0_empty", 64'(exp_q[2].size()), 64'd0);
        chk("t6_q1_empty", 64'(exp_q[3].size()), 64'd0);
        chk("t6_recv0", 64'(recv[2]), 64'd100);
        chk("t6_recv1", 64'(recv[3]), 64'd100);
        chk("t6_idle_resp0", 64'(p_resp0_valid), 64'd0);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
